// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller: level/edge pending latch, mie/gie masking, lowest-index priority, req/claim/complete handshake.
// Latency 2 cycles request->irq_o; irq_o held until ack or withdrawal; no nesting while a claim is in service.
module miriscv_irq_ctrl #(
  parameter int unsigned          NUM_IRQ    = 32,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '0,
  parameter int unsigned          CAUSE_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_IRQ-1:0] int_req_i,
  output logic [NUM_IRQ-1:0] int_fin_o,
  input  logic [NUM_IRQ-1:0] mie_i,
  input  logic               gie_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  input  logic               irq_ack_i,
  input  logic               irq_ret_i
);

  localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERV
  } state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_fin;
  logic [IW-1:0]      r_id;
  logic               r_irq;

  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_id_oh;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [IW-1:0]      w_sel;
  logic [30:0]        w_cause_val;

  assign w_elig  = r_pend & mie_i & {NUM_IRQ{gie_i}};
  assign w_id_oh = NUM_IRQ'(1) << r_id;
  assign w_clr   = (r_state == S_REQ && irq_ack_i) ? w_id_oh : '0;

  // Descending scan so the lowest set index is the last assignment to stick.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = IW'(i);
    end
  end

  // Edge channels: a new edge coinciding with the claim survives it.
  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) w_pend_nxt[i] = (int_req_i[i] & ~r_prev[i]) | (r_pend[i] & ~w_clr[i]);
      else              w_pend_nxt[i] = int_req_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend <= '0;
      r_prev <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_prev <= int_req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_irq   <= 1'b0;
      r_fin   <= '0;
    end else begin
      r_fin <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_id    <= w_sel;
            r_irq   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ack_i) begin
            r_irq   <= 1'b0;
            r_state <= S_SERV;
          end else if (!w_elig[r_id]) begin
            r_irq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SERV: begin
          if (irq_ret_i) begin
            r_fin   <= w_id_oh;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_cause_val = 31'(CAUSE_BASE) + 31'(r_id);
  assign irq_o       = r_irq;
  assign irq_cause_o = r_irq ? {1'b1, w_cause_val} : 32'h0;
  assign int_fin_o   = r_fin;

endmodule

// File: doc/miriscv_irq_ctrl.md
# miriscv_irq_ctrl

Parametrised interrupt controller between peripheral request lines and the miriscv core. Latches requests per channel in level or edge mode, masks them with the core's `mie`/`mstatus.MIE`, and selects the lowest-index pending source. It then runs a request/claim/complete handshake with the core's trap logic and returns a one-cycle completion pulse to the serviced source. It replaces direct wiring of the 32-bit request bus into the CSR unit.

## Interface
- `NUM_IRQ`, default 32: number of request channels, 1..32.
- `EDGE_MASK`, default `'0`: `NUM_IRQ` bits; bit i = 1 makes channel i rising-edge sensitive, 0 makes it level sensitive.
- `CAUSE_BASE`, default 16: exception code reported for channel 0. Channel i reports `CAUSE_BASE + i`.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `int_req_i` in `NUM_IRQ`: peripheral requests, synchronous to `clk_i`.
- `int_fin_o` out `NUM_IRQ`: one-hot, one-cycle completion pulse to the serviced channel.
- `mie_i` in `NUM_IRQ`: per-channel enable from CSR `mie`.
- `gie_i` in 1: global enable (`mstatus.MIE`).
- `irq_o` out 1: interrupt request to the core.
- `irq_cause_o` out 32: mcause value, `{1'b1, 31'(CAUSE_BASE + id)}`; valid while `irq_o`=1.
- `irq_ack_i` in 1: core entered the trap for the current `irq_cause_o` (claim).
- `irq_ret_i` in 1: core executed `mret` for the claimed interrupt (complete).

## Operation
- **Pending register `pend_q`, one bit per channel.**
  - Level channel: `pend_q[i] <= int_req_i[i]`.
  - Edge channel: `prev_q[i] <= int_req_i[i]`. The bit sets on `int_req_i[i] & ~prev_q[i]` and clears at claim of channel i. If set and clear happen in the same cycle, set wins.
- **Eligibility and arbitration.**
  - `elig = pend_q & mie_i & {NUM_IRQ{gie_i}}`.
  - Fixed priority: the lowest set index of `elig` wins and is called `sel`.
- **FSM states: IDLE, REQ, SERV.**
  - IDLE:
    - If `elig` != 0: latch `id_q <= sel`, go to REQ.
    - Otherwise stay.
  - REQ (`irq_o`=1, `irq_cause_o` from `id_q`):
    - `id_q` is frozen; a higher-priority arrival does not change it.
    - If `irq_ack_i`=1: go to SERV. For an edge channel, clear `pend_q[id_q]`.
    - Otherwise, if `elig[id_q]`=0 (level dropped or mask cleared): go to IDLE, no fin pulse.
    - `irq_ack_i` takes precedence over the withdrawal check in the same cycle.
  - SERV (`irq_o`=0):
    - No nesting; new requests stay pending.
    - On `irq_ret_i`=1: pulse `int_fin_o[id_q]` and go to IDLE.
- `irq_ack_i` outside REQ and `irq_ret_i` outside SERV are ignored.
- `irq_cause_o` is 0 when `irq_o`=0.
- `NUM_IRQ`=1 is legal; `id_q` is then 1 bit wide, fixed at 0.

## Timing
- Reset values: state IDLE, `pend_q`=0, `prev_q`=0, `id_q`=0, `irq_o`=0, `irq_cause_o`=0, `int_fin_o`=0.
- Reset is asynchronous, mid-handshake included: the FSM goes directly to IDLE with no fin pulse, and all pending state is lost.
- `irq_o` is registered.
  - `int_req_i` sampled high at edge k: `pend_q` is set after k, the FSM enters REQ after k+1, and `irq_o`=1 during cycle k+2.
  - Total latency: 2 cycles.
- `irq_ack_i` sampled at edge m: `irq_o`=0 from cycle m+1.
- `irq_ret_i` sampled at edge r: `int_fin_o[id_q]`=1 for exactly cycle r+1.
  - The FSM is in IDLE in cycle r+1.
  - A still-pending request raises `irq_o` at r+2, giving a minimum 1-cycle gap between interrupts.
- Edge channel re-firing: a rising edge during REQ or SERV of the same channel is kept if it arrives after the claim edge. At most one edge is remembered per channel.
- `mie_i`/`gie_i` changes take effect on eligibility in the same cycle (combinational into IDLE/REQ decisions).

## Test plan
- **Level request with service.**
  - Stimulus: `mie_i`=`32'h0008_0000`, `gie_i`=1, raise `int_req_i[19]`.
  - Required: `irq_o`=1 two cycles later with `irq_cause_o`=`32'h8000_0023`.
  - Then pulse ack, then ret: `int_fin_o`=`32'h0008_0000` for one cycle.
- **Priority.**
  - Stimulus: raise channels 5 and 3 in the same cycle, all enabled.
  - Required: cause `32'h8000_0013` first. After ret, channel 5 (`32'h8000_0015`) follows with a 1-cycle `irq_o`-low gap.
- **Edge mode** (`EDGE_MASK` bit 7 = 1).
  - Stimulus: one-cycle pulse on `int_req_i[7]`.
  - Required: `irq_o` asserts even though the input has fallen.
  - A second pulse during SERV yields a second REQ after ret. A second pulse during REQ (before ack) yields only one service.
- **Masking and withdrawal.**
  - Stimulus: `gie_i`=0 with channel 2 pending.
  - Required: `irq_o` stays 0. Setting `gie_i`=1 gives `irq_o` 1 cycle later.
  - In REQ, clearing `mie_i[2]` without ack: `irq_o` drops next cycle, no `int_fin_o` pulse.
- **Ack/withdraw collision.**
  - Stimulus: level channel 0 drops in the same cycle `irq_ack_i`=1.
  - Required: enter SERV; ret still yields `int_fin_o[0]`.
- **Reset in SERV.**
  - Stimulus: assert `rst_n_i`=0 asynchronously while in SERV.
  - Required: `irq_o`, `irq_cause_o`, `int_fin_o` all 0 immediately.
  - After release: no fin pulse, and a level request re-arms with 2-cycle latency.
